srambank_rr_arbiter: RTL
========================

// Module: srambank_rr_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM bank (1 op/cycle, write-priority, latched read data) among NREQ requesters.
//  Round-robin arbitration; valid/ready request handshake; fixed-latency read response.
//  Sits between the requesters and the bank's clk/ADDRESS/wd/banksel/read/write/dataout pins.
// PARAMETERS
//  NREQ    2   number of requesters (2..8)
//  ADDR_W  8   bank address width
//  DATA_W  80  bank data width
// PORTS
//  clk          in   1              clock; also drives the bank
//  reset        in   1              synchronous, active-high reset
//  req_valid    in   NREQ           request present, per requester
//  req_write    in   NREQ           1=write, 0=read
//  req_addr     in   NREQ*ADDR_W    flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
//  req_wd       in   NREQ*DATA_W    flattened write data, same packing
//  req_ready    out  NREQ           one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
//  rsp_valid    out  NREQ           one-hot; read data for requester i is on rsp_data
//  rsp_data     out  DATA_W         read data; equals bank dataout
//  bank_addr    out  ADDR_W         to bank ADDRESS
//  bank_wd      out  DATA_W         to bank wd
//  bank_sel     out  1              to bank banksel
//  bank_read    out  1              to bank read
//  bank_write   out  1              to bank write
//  bank_dout    in   DATA_W         from bank dataout
// BEHAVIOUR
//  - Reset, sync active-high, takes effect at clk posedge: rr_ptr=0, rsp_valid=0.
//    While reset is high, req_ready=0 and bank_sel/read/write=0 combinationally.
//  - Arbitration is combinational each cycle. Search order: rr_ptr, rr_ptr+1, ... mod NREQ.
//    The first requester with req_valid=1 gets req_ready. At most one bit of req_ready is high.
//  - req_ready[i] may depend on req_valid; req_valid must not depend on req_ready.
//  - Accept in cycle T: bank_sel=1, bank_addr/bank_wd = winner's fields,
//    bank_write=req_write[winner], bank_read=~req_write[winner], all in cycle T (same edge).
//  - With no accept: bank_sel=bank_read=bank_write=0. bank_addr/bank_wd hold the last value (no toggling).
//  - Pointer update: after an accept by i, rr_ptr <= (i+1) mod NREQ. With no accept, rr_ptr holds.
//  - Read latency 1: a read accepted in cycle T gives rsp_valid[i]=1 in cycle T+1 only.
//    rsp_data=bank_dout is valid in that cycle. No response backpressure: the requester must sample it.
//  - Writes produce no response. Data is visible to a read accepted in cycle T+1 or later.
//  - Back-to-back: one accept per cycle sustained. A read at T and a read at T+1 both respond, at T+1 and T+2.
//  - Outside rsp_valid, rsp_data keeps the last read value, because the bank latches dataout.
//  - Reset mid-operation: a read accepted in the cycle where reset is sampled produces no rsp_valid.
//  - A req_valid that is held and not granted waits. Starvation bound: NREQ-1 cycles.
// STRUCTURE
//  - Package srambank_ctrl_pkg: ADDR_W, DATA_W and NREQ defaults, plus the one-hot grant typedef.
//  - Sub-module rr_arb_core: inputs NREQ valids and rr_ptr; outputs one-hot grant and the encoded index.
//  - Top level holds rr_ptr, the rsp pipeline register (read-accept plus index) and the bank muxes.
// TESTING
//  (bench instantiates srambank_64x4x80 model behind the arbiter, NREQ=2)
//  1. reset=1 for 3 cycles with all req_valid=1 -> req_ready=0, bank_sel=0, rsp_valid=0.
//     Release reset -> requester 0 granted first.
//  2. Req0 writes addr 0x05 data 0xA5..A5; next cycle req0 reads 0x05
//     -> rsp_valid=01 one cycle after the read accept, rsp_data=0xA5..A5.
//  3. Both valid continuously with reads of 0x10 and 0x20
//     -> grants alternate 01,10,01,10; rsp_valid follows one cycle later with the matching data.
//  4. Only req1 valid for 5 cycles -> req1 granted every cycle, rr_ptr stays steering to 0.
//     Then both valid -> req0 granted first.
//  5. Req0 reads 0xFF (top address) at T, and reset is sampled at T
//     -> no rsp_valid at T+1, rr_ptr=0 afterwards.
//  6. Req1 writes 0x33 at T, req0 reads 0x33 at T+1 -> rsp_data equals the req1 data at T+2.
//     rsp_data stays unchanged through idle cycles.

Source files
------------

// File: rtl/srambank_ctrl_pkg.sv
// Shared sizing defaults and the one-hot grant type for the SRAM bank round-robin front end.
package srambank_ctrl_pkg;

  localparam int unsigned NREQ_DEF   = 2;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 80;

  // Widest supported requester count; narrower instances truncate the grant.
  localparam int unsigned NREQ_MAX   = 8;
  localparam int unsigned IDX_MAX_W  = 3;

  typedef logic [NREQ_MAX-1:0] grant_t;

  function automatic grant_t idx_to_grant(input logic [IDX_MAX_W-1:0] idx);
    return grant_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping mod NREQ.
module rr_arb_core
  import srambank_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!found && valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    grant = found ? NREQ'(idx_to_grant(IDX_MAX_W'(idx))) : '0;
  end

endmodule

// File: rtl/srambank_rr_arbiter.sv
// Round-robin front end sharing one single-port synchronous SRAM bank among NREQ requesters.
module srambank_rr_arbiter
  import srambank_ctrl_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wd,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        bank_addr,
  output logic [DATA_W-1:0]        bank_wd,
  output logic                     bank_sel,
  output logic                     bank_read,
  output logic                     bank_write,
  input  logic [DATA_W-1:0]        bank_dout
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [NREQ-1:0]   grant;
  logic              accept;
  logic              win_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              rd_pend_q;
  logic [IDX_W-1:0]  rd_idx_q;

  rr_arb_core #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_core (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // Bank muxes; address/data hold their last value when idle to avoid toggling the pins.
  always_comb begin
    accept    = ~reset & (|grant);
    req_ready = reset ? '0 : grant;
    win_write = 1'b0;
    bank_addr = addr_q;
    bank_wd   = wd_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (accept && grant[i]) begin
        win_write = req_write[i];
        bank_addr = req_addr[i*ADDR_W +: ADDR_W];
        bank_wd   = req_wd[i*DATA_W +: DATA_W];
      end
    end
    bank_sel   = accept;
    bank_write = accept & win_write;
    bank_read  = accept & ~win_write;
  end

  // The bank latches dataout, so rsp_data is the pin itself; only the strobe is pipelined.
  assign rsp_data  = bank_dout;
  assign rsp_valid = rd_pend_q ? NREQ'(idx_to_grant(IDX_MAX_W'(rd_idx_q))) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
    end else begin
      rd_pend_q <= bank_read;
      rd_idx_q  <= win_idx;
      if (accept) begin
        rr_ptr <= (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
        addr_q <= bank_addr;
        wd_q   <= bank_wd;
      end
    end
  end

endmodule
